dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, data memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter SB_DEPTH, default 4, store-buffer entries (power of two).
REQ-003 SHALL have parameter PREG_W, default 7, physical-register tag width.
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports: st_valid  in  1  retired store from LSQ store_wb; st_addr  in  32  store byte address; st_data  in  32  store data; st_half  in  1  1=sh, 0=sw.
REQ-006 SHALL have port: sb_full  out  1  store buffer holds SB_DEPTH entries.
REQ-007 SHALL have ports: ld_valid  in  1  load request; ld_addr  in  32  load byte address; ld_func3  in  3  010=lw, 100=lbu; ld_pd  in  PREG_W  destination preg; ld_rob_tag  in  5  ROB tag; ld_ready  out  1  load accepted when high with ld_valid.
REQ-008 SHALL have ports: resp_valid  out  1; resp_data  out  32; resp_pd  out  PREG_W; resp_rob_tag  out  5; resp_ready  in  1  consumer accepts response.
REQ-009 SHALL have port: flush  in  1  squash in-flight load (mispredict).

Function
REQ-010 Memory SHALL be little-endian word array; word index = addr[log2(MEM_WORDS)+1:2], byte = addr[1:0]; upper bits ignored.
REQ-011 Store buffer SHALL be circular FIFO with head/tail pointers wrapping SB_DEPTH-1 -> 0 and a count; sb_full = (count == SB_DEPTH).
REQ-012 st_valid while !sb_full SHALL push {addr, data, half} at tail; st_valid while sb_full SHALL be ignored.
REQ-013 Push and pop in same cycle SHALL leave count unchanged; both pointers advance.
REQ-014 Drain: in IDLE with no load handshake that cycle, or in RESP, a non-empty buffer SHALL write head entry to memory and pop, one entry per cycle.
REQ-015 Drain writes: sw SHALL write all 4 bytes of word; sh SHALL write bytes {1,0} if addr[1]=0 else bytes {3,2}.
REQ-016 FSM states IDLE, READ, RESP; reset to IDLE.
REQ-017 IDLE: ld_ready = !hazard; ld_valid && ld_ready SHALL capture addr, func3, pd, rob_tag and go to READ.
REQ-018 READ: memory word SHALL be read; next state RESP.
REQ-019 RESP: resp_valid = 1 with captured pd/rob_tag; lw returns word, lbu returns selected byte zero-extended; other func3 SHALL behave as lw.
REQ-020 RESP with resp_ready SHALL return to IDLE next cycle; without resp_ready outputs SHALL hold stable.
REQ-021 Load latency SHALL be accept at T, resp_valid at T+2 (minimum).
REQ-022 flush in READ or RESP SHALL return FSM to IDLE next cycle, resp_valid low; flush SHALL NOT affect store buffer (stores are retired).
REQ-023 flush in IDLE SHALL force ld_ready low that cycle.
REQ-024 ld_ready SHALL be 0 outside IDLE.

Reset
REQ-025 reset SHALL clear state to IDLE, count/head/tail to 0, sb_full 0, ld_ready 0 during reset, resp_valid/resp_data/resp_pd/resp_rob_tag 0.
REQ-026 Memory array SHALL NOT be reset; reset mid-load SHALL discard the load and all buffered stores.

Configuration
REQ-027 Macro DMEM_FWD_EN defined: if youngest buffered entry with matching word index is sw, load SHALL be accepted and its data taken from that entry (byte select per REQ-019); if youngest match is sh, hazard=1.
REQ-028 DMEM_FWD_EN undefined: hazard=1 whenever any buffered entry matches load word index.

Structure
REQ-029 types_pkg SHALL hold sb_entry_t struct {addr, data, half}, dmem_state_t enum, and func3 constants FUNC3_LW/FUNC3_LBU/FUNC3_SW/FUNC3_SH.
REQ-030 Store buffer SHALL be sub-module dmem_store_buf (FIFO plus combinational word-match/youngest-match search); FSM and array in dmem_ctrl.

Verification
REQ-031 sw 0x100 <- 0xDEADBEEF, drain, lw 0x100 -> resp_data 0xDEADBEEF at T+2, pd/rob_tag echoed.
REQ-032 sw 0x104 <- 0x11223344, drain, sh 0x106 <- 0xAABB, drain, lbu 0x107 -> 0x000000AA, lw 0x104 -> 0xAABB3344.
REQ-033 Four stores without drain opportunity (loads held in RESP, resp_ready=0 but drain ongoing disabled via back-to-back loads) -> sb_full=1, fifth st_valid dropped, pointers wrap correctly after drain.
REQ-034 Buffered sw 0x200 <- 0x12345678 then lw 0x200: FWD_EN -> accepted, 0x12345678; no FWD_EN -> ld_ready=0 until drained, then 0x12345678.
REQ-035 Load in RESP, resp_ready=0 for 3 cycles -> outputs stable; flush -> resp_valid 0 next cycle, FSM IDLE, buffered stores still drain.
REQ-036 reset asserted in READ -> all outputs 0 immediately, count 0, IDLE after release.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the data-memory controller: store-buffer entry, FSM states,
// load/store func3 encodings and the load byte-select helper.
package types_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_SW  = 3'b010;
    localparam logic [2:0] FUNC3_SH  = 3'b001;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic            half;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    // lbu returns the addressed byte zero-extended; every other func3 returns the word
    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [1:0]      byte_sel,
                                                     input logic [2:0]      func3);
        logic [7:0] sel_byte;
        sel_byte = word[{byte_sel, 3'b000} +: 8];
        if (func3 == FUNC3_LBU) begin
            return XLEN'(sel_byte);
        end
        return word;
    endfunction

endpackage

// File: rtl/dmem_store_buf.sv
// Circular store buffer holding retired stores until they drain to memory,
// with a combinational search for the youngest entry hitting a given word index.
module dmem_store_buf
    import types_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4,
    parameter int unsigned IDX_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  sb_entry_t        push_entry_i,
    input  logic             pop_i,
    output sb_entry_t        head_o,
    output logic             empty_o,
    output logic             full_o,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             match_any_o,
    output sb_entry_t        match_entry_o
);

    localparam int unsigned PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(SB_DEPTH + 1);

    sb_entry_t        entries_q [SB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;
    logic [PTR_W-1:0] slot;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(SB_DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = entries_q[head_q];

    // Pointer/count next-state; simultaneous push and pop keep the count
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            tail_d = ptr_inc(tail_q);
        end
        if (pop_ok) begin
            head_d = ptr_inc(head_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless outside the valid window
    always_ff @(posedge clk) begin
        if (push_ok) begin
            entries_q[tail_q] <= push_entry_i;
        end
    end

    // Walk oldest to youngest so the last hit left standing is the youngest
    always_comb begin
        match_any_o   = 1'b0;
        match_entry_o = '0;
        slot          = '0;
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            slot = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) &&
                (entries_q[slot].addr[IDX_W+1:2] == lookup_idx_i)) begin
                match_any_o   = 1'b1;
                match_entry_o = entries_q[slot];
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word array, store buffer drain and a single
// outstanding load (IDLE -> READ -> RESP). Define DMEM_FWD_EN to let loads
// take data from a youngest buffered sw instead of waiting for it to drain.
module dmem_ctrl
    import types_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned SB_DEPTH  = 4,
    parameter int unsigned PREG_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic              st_half,
    output logic              sb_full,
    input  logic              ld_valid,
    input  logic [31:0]       ld_addr,
    input  logic [2:0]        ld_func3,
    input  logic [PREG_W-1:0] ld_pd,
    input  logic [4:0]        ld_rob_tag,
    output logic              ld_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [PREG_W-1:0] resp_pd,
    output logic [4:0]        resp_rob_tag,
    input  logic              resp_ready,
    input  logic              flush
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    dmem_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        byte_q, byte_d;
    logic [2:0]        func3_q, func3_d;
    logic [PREG_W-1:0] pd_q, pd_d;
    logic [4:0]        rob_q, rob_d;
    logic              fwd_hit_q, fwd_hit_d;
    logic [31:0]       fwd_data_q, fwd_data_d;
    logic [31:0]       resp_data_q, resp_data_d;

    logic [31:0]       mem_q [MEM_WORDS];

    sb_entry_t         st_entry;
    sb_entry_t         sb_head;
    sb_entry_t         sb_match;
    logic              sb_empty;
    logic              sb_match_any;
    logic              hazard;
    logic              fwd_hit;
    logic              capture;
    logic              drain;
    logic [IDX_W-1:0]  head_idx;
    logic [31:0]       rd_word;
    logic              unused_bits;

    assign st_entry.addr = st_addr;
    assign st_entry.data = st_data;
    assign st_entry.half = st_half;

    dmem_store_buf #(
        .SB_DEPTH (SB_DEPTH),
        .IDX_W    (IDX_W)
    ) u_sb (
        .clk           (clk),
        .reset         (reset),
        .push_i        (st_valid),
        .push_entry_i  (st_entry),
        .pop_i         (drain),
        .head_o        (sb_head),
        .empty_o       (sb_empty),
        .full_o        (sb_full),
        .lookup_idx_i  (ld_addr[IDX_W+1:2]),
        .match_any_o   (sb_match_any),
        .match_entry_o (sb_match)
    );

`ifdef DMEM_FWD_EN
    // A youngest sw covers the whole word and can be forwarded; a youngest sh cannot
    assign fwd_hit = sb_match_any && !sb_match.half;
    assign hazard  = sb_match_any && sb_match.half;
`else
    assign fwd_hit = 1'b0;
    assign hazard  = sb_match_any;
`endif

    assign head_idx = sb_head.addr[IDX_W+1:2];
    assign rd_word  = fwd_hit_q ? fwd_data_q : mem_q[idx_q];

    assign resp_valid   = (state_q == ST_RESP);
    assign resp_data    = resp_data_q;
    assign resp_pd      = pd_q;
    assign resp_rob_tag = rob_q;

    assign unused_bits = ^{ld_addr[31:IDX_W+2], sb_head.addr[31:IDX_W+2], sb_head.addr[0],
                           sb_match.addr, sb_match.half};

    // Load FSM next state, load acceptance and drain opportunity
    always_comb begin
        state_d  = state_q;
        ld_ready = 1'b0;
        capture  = 1'b0;
        drain    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ld_ready = !hazard && !flush && !reset;
                if (ld_valid && ld_ready) begin
                    capture = 1'b1;
                    state_d = ST_READ;
                end else begin
                    drain = !sb_empty;
                end
            end
            ST_READ: begin
                state_d = flush ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                drain = !sb_empty;
                if (flush || resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Load context capture and response data formation
    always_comb begin
        idx_d       = idx_q;
        byte_d      = byte_q;
        func3_d     = func3_q;
        pd_d        = pd_q;
        rob_d       = rob_q;
        fwd_hit_d   = fwd_hit_q;
        fwd_data_d  = fwd_data_q;
        resp_data_d = resp_data_q;
        if (capture) begin
            idx_d      = ld_addr[IDX_W+1:2];
            byte_d     = ld_addr[1:0];
            func3_d    = ld_func3;
            pd_d       = ld_pd;
            rob_d      = ld_rob_tag;
            fwd_hit_d  = fwd_hit;
            fwd_data_d = sb_match.data;
        end
        if ((state_q == ST_READ) && !flush) begin
            resp_data_d = load_extract(rd_word, byte_q, func3_q);
        end
    end

    // State and load-context registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            byte_q      <= '0;
            func3_q     <= '0;
            pd_q        <= '0;
            rob_q       <= '0;
            fwd_hit_q   <= 1'b0;
            fwd_data_q  <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            func3_q     <= func3_d;
            pd_q        <= pd_d;
            rob_q       <= rob_d;
            fwd_hit_q   <= fwd_hit_d;
            fwd_data_q  <= fwd_data_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Drain the head store into the array; sh touches only its half-word
    always_ff @(posedge clk) begin
        if (drain) begin
            if (!sb_head.half) begin
                mem_q[head_idx] <= sb_head.data;
            end else if (sb_head.addr[1]) begin
                mem_q[head_idx][31:16] <= sb_head.data[15:0];
            end else begin
                mem_q[head_idx][15:0] <= sb_head.data[15:0];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed stores/loads; expected load responses are queued
// at acceptance and checked by an independent response monitor.
`timescale 1ns/1ps
module tb_dmem_ctrl;
    import types_pkg::*;

    localparam int unsigned PREG_W = 7;
    localparam logic [2:0] F3_OTHER = 3'b000;

    logic              clk = 1'b0;
    logic              reset;
    logic              st_valid;
    logic [31:0]       st_addr;
    logic [31:0]       st_data;
    logic              st_half;
    logic              sb_full;
    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic [2:0]        ld_func3;
    logic [PREG_W-1:0] ld_pd;
    logic [4:0]        ld_rob_tag;
    logic              ld_ready;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic [PREG_W-1:0] resp_pd;
    logic [4:0]        resp_rob_tag;
    logic              resp_ready;
    logic              flush;

    dmem_ctrl #(.MEM_WORDS(256), .SB_DEPTH(4), .PREG_W(PREG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_half      (st_half),
        .sb_full      (sb_full),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_func3     (ld_func3),
        .ld_pd        (ld_pd),
        .ld_rob_tag   (ld_rob_tag),
        .ld_ready     (ld_ready),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_pd      (resp_pd),
        .resp_rob_tag (resp_rob_tag),
        .resp_ready   (resp_ready),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]       data;
        logic [PREG_W-1:0] pd;
        logic [4:0]        tag;
        int                acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic h);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_half  = h;
        step();
        st_valid = 1'b0;
    endtask

    // Hold ld_valid until accepted; the expected response is queued on acceptance
    task automatic issue_load(input logic [31:0] a, input logic [2:0] f3,
                              input logic [PREG_W-1:0] pd, input logic [4:0] tag,
                              input logic [31:0] exp_data, output int waits);
        exp_t e;
        ld_valid   = 1'b1;
        ld_addr    = a;
        ld_func3   = f3;
        ld_pd      = pd;
        ld_rob_tag = tag;
        waits      = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ld_ready) begin
                e.data = exp_data;
                e.pd   = pd;
                e.tag  = tag;
                e.acc  = cyc;
                exp_q.push_back(e);
                break;
            end
            waits++;
            if (waits == 60) begin
                chk("ld_accept_timeout", 32'(ld_ready), 32'd1);
                break;
            end
            step();
        end
        step();
        ld_valid = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [PREG_W-1:0] pd,
                      input logic [4:0] tag, input logic [31:0] exp_data);
        int w;
        issue_load(a, f3, pd, tag, exp_data, w);
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            chk("resp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // Response monitor: every visible resp cycle must match the head expectation
    initial begin : monitor
        bit   seen;
        exp_t cur;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 1'b0;
            end else if (resp_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        chk("resp_unexpected", 32'(resp_valid), 32'd0);
                    end else begin
                        cur  = exp_q.pop_front();
                        seen = 1'b1;
                        chk("resp_latency", 32'(cyc - cur.acc), 32'd2);
                    end
                end
                if (seen) begin
                    chk("resp_data", resp_data, cur.data);
                    chk("resp_pd", 32'(resp_pd), 32'(cur.pd));
                    chk("resp_rob_tag", 32'(resp_rob_tag), 32'(cur.tag));
                end
                if (resp_ready || flush) seen = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w;
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_half = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_func3 = '0; ld_pd = '0; ld_rob_tag = '0;
        resp_ready = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_pd", 32'(resp_pd), 32'd0);
        chk("rst_resp_tag", 32'(resp_rob_tag), 32'd0);
        chk("rst_sb_full", 32'(sb_full), 32'd0);
        step();
        reset = 1'b0;
        step();

        // sw then lw of the same word after draining
        st(32'h100, 32'hDEADBEEF, 1'b0);
        idle(2);
        ld(32'h100, FUNC3_LW, 7'h15, 5'h0A, 32'hDEADBEEF);
        wait_resp();

        // preload words used by later checks
        st(32'h414, 32'hCAFEF00D, 1'b0);
        st(32'h1F0, 32'h600D0001, 1'b0);
        idle(3);

        // sh merging and byte extraction
        st(32'h104, 32'h11223344, 1'b0);
        idle(2);
        st(32'h106, 32'h0000AABB, 1'b1);
        idle(2);
        ld(32'h107, FUNC3_LBU, 7'h01, 5'h01, 32'h000000AA);
        ld(32'h104, FUNC3_LW,  7'h02, 5'h02, 32'hAABB3344);
        ld(32'h104, FUNC3_LBU, 7'h03, 5'h03, 32'h00000044);
        ld(32'h105, FUNC3_LBU, 7'h04, 5'h04, 32'h00000033);
        ld(32'h104, F3_OTHER,  7'h05, 5'h05, 32'hAABB3344);
        ld(32'h8000_0100, FUNC3_LW, 7'h06, 5'h06, 32'hDEADBEEF);
        wait_resp();
        st(32'h104, 32'hFFFF9999, 1'b1);
        idle(2);
        ld(32'h104, FUNC3_LW, 7'h07, 5'h07, 32'hAABB9999);
        wait_resp();

        // load hitting a buffered sw: forwarded or blocked until drained
        st(32'h200, 32'h12345678, 1'b0);
        issue_load(32'h200, FUNC3_LW, 7'h08, 5'h08, 32'h12345678, w);
`ifdef DMEM_FWD_EN
        chk("sw_fwd_wait", 32'(w), 32'd0);
`else
        chk("sw_hazard_wait", 32'(w), 32'd1);
`endif
        wait_resp();
        st(32'h208, 32'hA1B2C3D4, 1'b0);
        issue_load(32'h20A, FUNC3_LBU, 7'h09, 5'h09, 32'h000000B2, w);
`ifdef DMEM_FWD_EN
        chk("lbu_fwd_wait", 32'(w), 32'd0);
`else
        chk("lbu_hazard_wait", 32'(w), 32'd1);
`endif
        wait_resp();
        st(32'h300, 32'h00005566, 1'b1);
        issue_load(32'h300, FUNC3_LBU, 7'h0A, 5'h0A, 32'h00000066, w);
        chk("sh_hazard_wait", 32'(w), 32'd1);
        ld(32'h301, FUNC3_LBU, 7'h0B, 5'h0B, 32'h00000055);
        wait_resp();
        idle(3);

        // fill the buffer while back-to-back loads suppress most drains
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    st_valid = 1'b1;
                    st_addr  = 32'h400 + 32'(4 * i);
                    st_data  = 32'hF000_0000 | 32'(i);
                    st_half  = 1'b0;
                    @(negedge clk);
                    chk($sformatf("sb_full_fill%0d", i), 32'(sb_full), (i == 5) ? 32'd1 : 32'd0);
                    step();
                end
                st_valid = 1'b0;
            end
            begin
                ld(32'h100, FUNC3_LW, 7'h10, 5'h10, 32'hDEADBEEF);
                ld(32'h100, FUNC3_LW, 7'h11, 5'h11, 32'hDEADBEEF);
            end
        join
        wait_resp();
        idle(4);
        @(negedge clk);
        chk("sb_full_drained", 32'(sb_full), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            ld(32'h400 + 32'(4 * i), FUNC3_LW, 7'(8'h20 + i), 5'(i), 32'hF000_0000 | 32'(i));
        end
        ld(32'h414, FUNC3_LW, 7'h2F, 5'h1F, 32'hCAFEF00D);
        wait_resp();

        // held response, then flush; buffered store still drains
        resp_ready = 1'b0;
        ld(32'h104, FUNC3_LW, 7'h2A, 5'h11, 32'hAABB9999);
        idle(4);
        flush    = 1'b1;
        st_valid = 1'b1;
        st_addr  = 32'h50C;
        st_data  = 32'h0BADF00D;
        st_half  = 1'b0;
        step();
        flush    = 1'b0;
        st_valid = 1'b0;
        @(negedge clk);
        chk("flush_resp_valid", 32'(resp_valid), 32'd0);
        chk("flush_idle_ready", 32'(ld_ready), 32'd1);
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_ld_ready", 32'(ld_ready), 32'd0);
        step();
        flush      = 1'b0;
        resp_ready = 1'b1;
        ld(32'h50C, FUNC3_LW, 7'h2B, 5'h12, 32'h0BADF00D);
        wait_resp();
        idle(2);

        // reset while a load is in READ with a store buffered
        st_valid = 1'b1;
        st_addr  = 32'h1F0;
        st_data  = 32'hBAD00BAD;
        st_half  = 1'b0;
        ld(32'h104, FUNC3_LW, 7'h3C, 5'h1C, 32'hAABB9999);
        st_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("rst_read_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_read_resp_data", resp_data, 32'd0);
        chk("rst_read_resp_pd", 32'(resp_pd), 32'd0);
        chk("rst_read_resp_tag", 32'(resp_rob_tag), 32'd0);
        chk("rst_read_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_read_sb_full", 32'(sb_full), 32'd0);
        exp_q.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);
        step();
        ld(32'h1F0, FUNC3_LW, 7'h3D, 5'h1D, 32'h600D0001);
        wait_resp();
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
